i2s_mono_port: RTL and testbench
================================

Name: i2s_mono_port

Overview:
- Single-channel I2S serial port, slave to external bclk/lrclk; runs entirely on the system clock `clk`, sampling bclk/lrclk as data.
- `sel_rx=1`: deserialises the left-channel slot from `rx` into `rx_pcm`.
- `sel_rx=0`: serialises `tx_pcm` onto `tx` in the left-channel slot.
- Sample-level flow control to the host uses `full` plus toggle acknowledges (`push`/`pop`).
- Sits between a PCM16 signed little-endian sample source/sink and an external codec or a peer port.

Parameters:
- SYNC_STAGES, 2, synchroniser depth for bclk, lrclk and rx into the `clk` domain.
- WORD_W, 16, PCM word width. Fixed; a parameter only for readability.

Ports:
- clk  in  1  system clock; must be ≥8× bclk frequency.
- rstn  in  1  asynchronous active-low reset.
- enable  in  1  port enable; low aborts activity.
- sel_rx  in  1  1=receive mode, 0=transmit mode; change only while enable=0.
- bclk  in  1  I2S bit clock, asynchronous to clk.
- lrclk  in  1  I2S word select; 0=left (active) half-frame.
- rx  in  1  serial data in.
- tx  out  1  serial data out.
- tx_pcm  in  16  signed sample to transmit.
- rx_pcm  out  16  signed received sample.
- align  in  5  bit-slot index (0..31) of the word LSB within the half-frame.
- push  in  1  transmit acknowledge, toggle-encoded.
- pop  in  1  receive acknowledge, toggle-encoded.
- full  out  1  sample event pending for the host.

Behaviour:
- Reset (rstn=0, asynchronous): full=0, tx=0, rx_pcm=0; shift registers, slot counter, synchronisers and push/pop shadow registers are cleared.
- Synchronisation: bclk, lrclk and rx each pass through SYNC_STAGES flops. One extra register per signal produces single-cycle rise/fall strobes.
- Slot counter (5 bit):
  - Cleared on any lrclk edge strobe.
  - Incremented on each bclk falling strobe after that; it is the slot index of the current bit.
  - Counts saturate at 31.
- Effective alignment: eff_align = max(align, 15). The word occupies slots eff_align-15 (MSB) through eff_align (LSB).
- Active half-frame is lrclk=0. The right half-frame is ignored for rx, and tx drives 0 during it.
- TX mode (sel_rx=0, enable=1):
  - On the lrclk falling strobe, tx_pcm is loaded into the shift register and full is set to 1.
  - tx presents the bit for the current slot, updated on the bclk falling strobe: MSB first inside the word window, 0 outside it.
  - tx_pcm is always sampled at frame start, even if the previous full was never acknowledged.
- RX mode (sel_rx=1, enable=1):
  - On each bclk rising strobe inside the word window while lrclk=0, synchronised rx is shifted in, MSB first.
  - On the rising strobe of slot eff_align, rx_pcm is updated with the completed word and full is set to 1.
  - Overrun: if full is already 1, rx_pcm is overwritten and full stays 1.
  - tx=0 in RX mode.
- Acknowledge:
  - The block keeps shadow registers push_q/pop_q.
  - A mismatch in the active direction (push in TX, pop in RX) is an ack; the shadow register updates to the input on the same edge.
  - An ack clears full on that clock edge.
  - An ack while full=0 is absorbed with no other effect.
  - If a set event and an ack coincide on the same edge, the set wins (full=1).
- Enable low: full=0, tx=0, slot counter and shift registers cleared; rx_pcm holds its value; shadow registers keep tracking push/pop.
- After enable rises, the block idles until the next lrclk falling strobe, so no partial first word is ever produced.

Decomposition:
- Shared package i2s_pkg holds: WORD_W=16, SLOT_MAX=31, typedef pcm16_t (signed [15:0]).
- One sub-module, i2s_edge_sync: synchroniser plus rise/fall strobe generator, instantiated three times (bclk, lrclk, rx; only the synchronised level is used for rx).

Test Plan:
- Reset: assert rstn=0 mid-frame → full=0, tx=0, rx_pcm=0 immediately, independent of clk.
- Loopback: two instances cross-wired (tx→rx), opposite sel_rx, align=15, tx_pcm=16'sh0100 → receiver rx_pcm=16'sh0100 one frame later, and full pulses once per frame on each side.
- Alignment: align=20, tx_pcm=16'h8001 → tx is high at slots 5 and 20 only; align=3 behaves exactly like align=15.
- Handshake: toggle pop every clk while full=1 → full clears on the first ack and the extra ack is absorbed; the next frame sets full again.
- Overrun: RX with no pop for 3 frames → full stays 1 and rx_pcm equals the latest word.
- Enable abort: drop enable mid-word then re-raise mid-frame → no word until the next lrclk falling edge; tx=0 throughout the abort window.

Source files
------------

// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_pkg
//  Purpose  : Shared types, constants and helpers for the mono I2S port.
//  Revision : 1.0  initial release
// ============================================================================
package i2s_pkg;

   localparam int WORD_W   = 16;
   localparam int SLOT_MAX = 31;

   typedef logic signed [WORD_W-1:0] pcm16_t;

   // A word needs 16 slots, so its LSB can never sit before slot 15.
   function automatic logic [4:0] eff_align(input logic [4:0] a);
      return (a < 5'd15) ? 5'd15 : a;
   endfunction

endpackage
`default_nettype wire

// File: rtl/i2s_edge_sync.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_edge_sync
//  Purpose  : Multi-flop synchroniser with single-cycle rise/fall strobes.
//  Revision : 1.0  initial release
// ============================================================================
module i2s_edge_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rstn,
   input  logic d_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   generate
      if (SYNC_STAGES > 1) begin : g_chain
         // Shift the asynchronous input through the synchroniser chain.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) sync_q <= '0;
            else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         end
      end else begin : g_single
         // Single-stage capture when only one flop is requested.
         always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) sync_q <= '0;
            else       sync_q <= d_i;
         end
      end
   endgenerate

   assign level_o = sync_q[SYNC_STAGES-1];

   // Remember the previous synchronised level for edge detection.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) prev_q <= 1'b0;
      else       prev_q <= level_o;
   end

   assign rise_o =  level_o & ~prev_q;
   assign fall_o = ~level_o &  prev_q;

endmodule
`default_nettype wire

// File: rtl/i2s_mono_port.sv
`default_nettype none
// ============================================================================
//  Module   : i2s_mono_port
//  Purpose  : Single-channel (left slot) I2S slave port, RX or TX, clocked
//             entirely by clk with bclk/lrclk treated as sampled data.
//  Revision : 1.0  initial release
// ============================================================================
module i2s_mono_port
   import i2s_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int WORD_W      = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              enable,
   input  logic              sel_rx,
   input  logic              bclk,
   input  logic              lrclk,
   input  logic              rx,
   output logic              tx,
   input  logic [WORD_W-1:0] tx_pcm,
   output logic [WORD_W-1:0] rx_pcm,
   input  logic [4:0]        align,
   input  logic              push,
   input  logic              pop,
   output logic              full
);

   logic bclk_lvl_unused, bclk_rise_w, bclk_fall_w;
   logic lr_lvl_w, lr_rise_w, lr_fall_w;
   logic rx_lvl_w, rx_rise_unused, rx_fall_unused;

   i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
      .clk(clk), .rstn(rstn), .d_i(bclk),
      .level_o(bclk_lvl_unused), .rise_o(bclk_rise_w), .fall_o(bclk_fall_w));

   i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrclk (
      .clk(clk), .rstn(rstn), .d_i(lrclk),
      .level_o(lr_lvl_w), .rise_o(lr_rise_w), .fall_o(lr_fall_w));

   i2s_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_rx (
      .clk(clk), .rstn(rstn), .d_i(rx),
      .level_o(rx_lvl_w), .rise_o(rx_rise_unused), .fall_o(rx_fall_unused));

   logic [4:0] slot_q, slot_d;
   logic       armed_q, armed_d;
   logic       full_q, full_d;
   logic       tx_q, tx_d;
   logic       push_q, pop_q;
   pcm16_t     tx_word_q, tx_word_d;
   pcm16_t     rx_shift_q, rx_shift_d;
   pcm16_t     rx_pcm_q, rx_pcm_d;

   logic [4:0] eff_w, lo_w;
   logic [3:0] tx_idx_w;
   logic       tx_win_w, rx_win_w, rx_take_w, rx_done_w, ack_w, set_w;

   // Next-state logic: slot tracking, word windows, serialiser, flow control.
   always_comb begin
      eff_w = eff_align(align);
      lo_w  = eff_w - 5'd15;

      // Slot counter restarts on either word-select edge and saturates.
      slot_d = slot_q;
      if (!enable)
         slot_d = 5'd0;
      else if (lr_rise_w || lr_fall_w)
         slot_d = 5'd0;
      else if (bclk_fall_w && (slot_q != 5'(SLOT_MAX)))
         slot_d = slot_q + 5'd1;

      // Nothing is produced until a full left half-frame begins.
      armed_d = armed_q;
      if (!enable)        armed_d = 1'b0;
      else if (lr_fall_w) armed_d = 1'b1;

      // Transmit word is captured at frame start regardless of host state.
      tx_word_d = tx_word_q;
      if (!enable)                   tx_word_d = '0;
      else if (lr_fall_w && !sel_rx) tx_word_d = pcm16_t'(tx_pcm);

      // Serial output follows the slot that is about to be current.
      tx_win_w = (slot_d >= lo_w) && (slot_d <= eff_w);
      tx_idx_w = 4'(eff_w - slot_d);
      tx_d     = 1'b0;
      if (armed_d && !sel_rx && !lr_lvl_w && tx_win_w)
         tx_d = tx_word_d[tx_idx_w];

      // Receive samples on bclk rise inside the left-slot word window.
      rx_win_w  = (slot_q >= lo_w) && (slot_q <= eff_w);
      rx_take_w = enable && sel_rx && armed_q && !lr_lvl_w && bclk_rise_w && rx_win_w;
      rx_done_w = rx_take_w && (slot_q == eff_w);

      rx_shift_d = rx_shift_q;
      if (!enable || lr_fall_w) rx_shift_d = '0;
      else if (rx_take_w)       rx_shift_d = {rx_shift_q[WORD_W-2:0], rx_lvl_w};

      rx_pcm_d = rx_pcm_q;
      if (rx_done_w) rx_pcm_d = {rx_shift_q[WORD_W-2:0], rx_lvl_w};

      // A toggle on the active-direction acknowledge clears full; a new
      // sample event on the same edge takes priority.
      ack_w = sel_rx ? (pop != pop_q) : (push != push_q);
      set_w = sel_rx ? rx_done_w : (enable && lr_fall_w);

      full_d = full_q;
      if (!enable)    full_d = 1'b0;
      else if (set_w) full_d = 1'b1;
      else if (ack_w) full_d = 1'b0;
   end

   // State registers; acknowledge shadows track their inputs every cycle.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slot_q     <= 5'd0;
         armed_q    <= 1'b0;
         full_q     <= 1'b0;
         tx_q       <= 1'b0;
         push_q     <= 1'b0;
         pop_q      <= 1'b0;
         tx_word_q  <= '0;
         rx_shift_q <= '0;
         rx_pcm_q   <= '0;
      end else begin
         slot_q     <= slot_d;
         armed_q    <= armed_d;
         full_q     <= full_d;
         tx_q       <= tx_d;
         push_q     <= push;
         pop_q      <= pop;
         tx_word_q  <= tx_word_d;
         rx_shift_q <= rx_shift_d;
         rx_pcm_q   <= rx_pcm_d;
      end
   end

   assign tx     = tx_q;
   assign full   = full_q;
   assign rx_pcm = rx_pcm_q;

endmodule
`default_nettype wire

// File: tb/tb_i2s_mono_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2s_mono_port
//  Purpose  : Two cross-wired ports (TX -> RX) with a scoreboard on the
//             receiver's sample events plus directed checks on the TX line.
//  Revision : 1.0  initial release
// ============================================================================
module tb_i2s_mono_port;

   localparam int HALF_BCLK = 80;   // 8 clk periods per bclk phase

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, enable, bclk, lrclk, push, pop;
   logic [4:0]  align;
   logic [15:0] tx_pcm;
   wire         tx_a, tx_r, full_t, full_r;
   wire  [15:0] rx_pcm_t, rx_pcm_r;

   i2s_mono_port u_tx (
      .clk(clk), .rstn(rstn), .enable(enable), .sel_rx(1'b0),
      .bclk(bclk), .lrclk(lrclk), .rx(1'b0), .tx(tx_a),
      .tx_pcm(tx_pcm), .rx_pcm(rx_pcm_t), .align(align),
      .push(push), .pop(1'b0), .full(full_t));

   i2s_mono_port u_rx (
      .clk(clk), .rstn(rstn), .enable(enable), .sel_rx(1'b1),
      .bclk(bclk), .lrclk(lrclk), .rx(tx_a), .tx(tx_r),
      .tx_pcm(16'h0000), .rx_pcm(rx_pcm_r), .align(align),
      .push(1'b0), .pop(pop), .full(full_r));

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Expected TX-line occupancy of the left half-frame for word w.
   function automatic logic [31:0] tx_pat(input logic [15:0] w, input int a);
      int e;
      logic [31:0] p;
      e = (a < 15) ? 15 : a;
      p = '0;
      for (int i = 0; i < 16; i++) p[e - 15 + i] = w[15 - i];
      return p;
   endfunction

   // ---------------- bit/frame clock generator and TX-line capture ---------
   logic        tb_half = 1'b1;
   int          tb_slot = 31;
   logic [31:0] cap_work = '0, cap_last = '0;
   int          right_bad = 0;

   initial begin
      bclk = 1'b1; lrclk = 1'b1;
      #3;
      forever begin
         for (int h = 0; h < 2; h++) begin
            for (int s = 0; s < 32; s++) begin
               bclk = 1'b0;
               if (s == 0) begin
                  lrclk   = (h == 1);
                  tb_half = (h == 1);
               end
               tb_slot = s;
               #HALF_BCLK;
               if (h == 0) cap_work[s] = tx_a;
               else if (tx_a) right_bad++;
               if (h == 0 && s == 31) cap_last = cap_work;
               bclk = 1'b1;
               #HALF_BCLK;
            end
         end
      end
   end

   // ---------------- scoreboard monitor on receiver sample events ----------
   logic [15:0] sb_q[$];
   logic        full_r_prev = 1'b0;
   logic [15:0] rx_prev = '0;

   always @(negedge clk) begin
      if (rstn && full_r && (!full_r_prev || rx_pcm_r != rx_prev)) begin
         if (sb_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL rx_word: got %h required no word", rx_pcm_r);
         end else begin
            check("rx_word", {16'h0, rx_pcm_r}, {16'h0, sb_q.pop_front()});
         end
      end
      full_r_prev = full_r;
      rx_prev     = rx_pcm_r;
   end

   // ---------------- host acknowledge models and event counters -----------
   logic auto_push = 1'b0, auto_pop = 1'b0, abort_win = 1'b0;
   logic ft_prev = 1'b0, fr_prev = 1'b0;
   int   n_tx_rise = 0, n_rx_rise = 0, abort_bad = 0;

   always @(negedge clk) begin
      if (auto_push && full_t) push = ~push;
      if (auto_pop && full_r)  pop  = ~pop;
      if (full_t && !ft_prev) n_tx_rise++;
      if (full_r && !fr_prev) n_rx_rise++;
      ft_prev = full_t;
      fr_prev = full_r;
      if (abort_win && (tx_a || full_t || full_r)) abort_bad++;
   end

   // ---------------- stimulus helpers --------------------------------------
   task automatic next_word(input logic [15:0] w, input bit expect_rx);
      wait (tb_half == 1'b1);
      tx_pcm = w;
      if (expect_rx) sb_q.push_back(w);
      wait (tb_half == 1'b0);
   endtask

   task automatic check_tx(input logic [31:0] exp, input string name);
      wait (tb_half == 1'b1);
      check(name, cap_last, exp);
   endtask

   task automatic wait_full_r(input string name);
      int n;
      n = 0;
      while (!full_r && n < 1200) begin
         @(negedge clk);
         n++;
      end
      check(name, {31'h0, full_r}, 32'h1);
   endtask

   // ---------------- directed sequence -------------------------------------
   int rt0, tt0;
   logic [15:0] loop_w [3] = '{16'h0100, 16'h1234, 16'h8000};

   initial begin
      rstn = 1'b1; enable = 1'b0; align = 5'd15; tx_pcm = '0;
      push = 1'b0; pop = 1'b0;
      #1 rstn = 1'b0;
      #20;
      check("rst_full_t", {31'h0, full_t}, 32'h0);
      check("rst_full_r", {31'h0, full_r}, 32'h0);
      check("rst_tx", {31'h0, tx_a}, 32'h0);
      check("rst_rx_pcm", {16'h0, rx_pcm_r}, 32'h0);
      #37 rstn = 1'b1;

      // Loopback at align 15: one event per frame on each side.
      wait (tb_half == 1'b1);
      enable = 1'b1; auto_push = 1'b1; auto_pop = 1'b1;
      rt0 = n_rx_rise; tt0 = n_tx_rise;
      for (int i = 0; i < 3; i++) begin
         next_word(loop_w[i], 1'b1);
         check_tx(tx_pat(loop_w[i], 15), "tx_loop");
      end
      check("rx_full_per_frame", n_rx_rise - rt0, 3);
      check("tx_full_per_frame", n_tx_rise - tt0, 3);

      // Alignment: MSB at slot 5 / LSB at 20; align 3 clamps to 15.
      align = 5'd20;
      next_word(16'h8001, 1'b1);
      check_tx(32'h0010_0020, "tx_align20");
      align = 5'd3;
      next_word(16'h8001, 1'b1);
      check_tx(32'h0000_8001, "tx_align3");
      align = 5'd15;

      // Handshake: first ack clears, extra ack absorbed, next frame sets.
      auto_pop = 1'b0;
      next_word(16'h5A5A, 1'b1);
      wait_full_r("hs_full_set");
      pop = ~pop;
      @(negedge clk);
      check("hs_ack_clears", {31'h0, full_r}, 32'h0);
      pop = ~pop;
      @(negedge clk);
      check("hs_extra_absorbed", {31'h0, full_r}, 32'h0);
      check("hs_rx_hold", {16'h0, rx_pcm_r}, 32'h5A5A);
      next_word(16'h1111, 1'b1);
      wait_full_r("hs_full_again");

      // Overrun: no pop across three frames.
      next_word(16'h2222, 1'b1);
      next_word(16'h3333, 1'b1);
      wait (tb_half == 1'b1);
      check("ovr_full", {31'h0, full_r}, 32'h1);
      check("ovr_latest", {16'h0, rx_pcm_r}, 32'h3333);
      @(negedge clk);
      pop = ~pop;
      @(negedge clk);
      check("ovr_pop", {31'h0, full_r}, 32'h0);
      auto_pop = 1'b1;

      // Enable abort mid-word, re-enable mid-word of the same frame.
      next_word(16'hFFFF, 1'b0);
      wait (tb_slot == 4);
      enable = 1'b0;
      @(posedge clk);
      #1 abort_win = 1'b1;
      #40;
      check("ab_tx_low", {31'h0, tx_a}, 32'h0);
      check("ab_rx_hold", {16'h0, rx_pcm_r}, 32'h3333);
      wait (tb_slot == 10);
      enable = 1'b1;
      wait (tb_half == 1'b1);
      tx_pcm = 16'h0F0F;
      sb_q.push_back(16'h0F0F);
      wait (tb_half == 1'b0);
      abort_win = 1'b0;
      check("ab_window_quiet", abort_bad, 0);
      check_tx(tx_pat(16'h0F0F, 15), "tx_after_abort");

      // Asynchronous reset mid-frame while the line is high and full is set.
      auto_pop = 1'b0;
      next_word(16'hFFFF, 1'b1);
      wait (tb_half == 1'b0 && tb_slot == 15);
      #(HALF_BCLK + 50);
      check("pre_rst_full_r", {31'h0, full_r}, 32'h1);
      check("pre_rst_tx", {31'h0, tx_a}, 32'h1);
      rstn = 1'b0;
      #1;
      check("arst_full_r", {31'h0, full_r}, 32'h0);
      check("arst_tx", {31'h0, tx_a}, 32'h0);
      check("arst_rx_pcm", {16'h0, rx_pcm_r}, 32'h0);
      #20;

      check("tx_right_half_zero", right_bad, 0);
      check("sb_drained", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time bound so the run always terminates.
   initial begin
      #600000;
      $display("FAIL watchdog: got timeout required completion");
      n_err++;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
